fetch_unit: RTL and testbench

Instruction fetch unit: produces the 32-bit instruction stream that the control unit decodes. Owns the program counter, issues in-order word reads to instruction memory over a request/grant plus response-valid interface, and buffers returned words in a small FIFO. Presents one instruction at a time to decode with a valid/ready handshake, and flushes on a branch/jump redirect from execute.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_unit_sync_fifo.sv | 53 +++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction fetch unit.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] alignPc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO with clear and occupancy count; holds returned instruction words.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
  assign w_doPop  = i_pop && (r_count != '0);
  assign w_doPush = i_push && ((r_count != CW'(DEPTH)) || w_doPop);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
      if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
      r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_doPush && !i_rst && !i_clear) r_mem[r_wrPtr] <= i_data;
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, issues in-order imem reads, buffers words
// for decode and flushes on redirect, dropping responses that were already in flight.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_imem_req,
  output logic [31:0]       o_imem_addr,
  input  logic              i_imem_gnt,
  input  logic              i_imem_rvalid,
  input  logic [31:0]       i_imem_rdata,
  input  logic              i_redirect,
  input  logic [31:0]       i_redirect_pc,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [INST_W-1:0] o_inst,
  output logic [31:0]       o_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

  logic [31:0]       r_pc;
  logic [31:0]       r_headPc;
  logic [CW-1:0]     r_inflight;
  logic [CW-1:0]     r_discard;
  logic [CW-1:0]     w_count;
  logic [INST_W-1:0] w_head;
  logic              w_grant;
  logic              w_stale;
  logic              w_push;
  logic              w_pop;

  assign w_stale = (r_discard != '0);
  assign w_grant = o_imem_req & i_imem_gnt;
  assign w_push  = i_imem_rvalid & !w_stale & !i_redirect;
  assign w_pop   = o_valid & i_ready;

  // Live requests are capped by free FIFO space; live plus stale by the memory's outstanding limit.
  assign o_imem_req = !i_rst
                      && (({1'b0, w_count} + {1'b0, r_inflight}) < DEPTH_X)
                      && (({1'b0, r_inflight} + {1'b0, r_discard}) < DEPTH_X);
  assign o_imem_addr = r_pc;
  assign o_valid     = (w_count != '0) && !i_redirect;
  assign o_inst      = o_valid ? w_head : NOP_INST;
  assign o_pc        = r_headPc;

  sync_fifo #(
    .WIDTH (INST_W),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_redirect),
    .i_push  (w_push),
    .i_data  (i_imem_rdata),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  // On redirect every request still owed by memory becomes stale, including one granted this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc       <= RESET_PC;
      r_headPc   <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else if (i_redirect) begin
      r_pc       <= alignPc(i_redirect_pc);
      r_headPc   <= alignPc(i_redirect_pc);
      r_inflight <= '0;
      r_discard  <= r_discard + r_inflight + CW'(w_grant) - CW'(i_imem_rvalid);
    end else begin
      if (w_grant) r_pc <= r_pc + 32'd4;
      if (w_pop)   r_headPc <= r_headPc + 32'd4;
      r_inflight <= r_inflight + CW'(w_grant) - CW'(i_imem_rvalid & !w_stale);
      r_discard  <= r_discard - CW'(i_imem_rvalid & w_stale);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model, queue-based reference
// model compared every cycle, plus directed literal checks on logged outputs.
module tb_fetch_unit;

  localparam int          DEPTH = 3;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic        ready = 1'b0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        o_valid;
  logic [31:0] o_inst;
  logic [31:0] o_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_gnt    (gnt),
    .i_imem_rvalid (rvalid),
    .i_imem_rdata  (rdata),
    .i_redirect    (redirect),
    .i_redirect_pc (rpc),
    .o_valid       (o_valid),
    .i_ready       (ready),
    .o_inst        (o_inst),
    .o_pc          (o_pc)
  );

  // Memory: in-order pending requests, each answered no earlier than its due cycle.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } memReq_t;
  memReq_t pend[$];
  int      cyc = 0;
  int      latMode = 0;
  int      latFixed = 1;

  // Reference model: addresses owed to us, addresses buffered for decode, stale count.
  logic [31:0] liveQ[$];
  logic [31:0] fifoQ[$];
  int          stale = 0;
  logic [31:0] mPc = RPC;
  logic [31:0] mHead = RPC;

  int nCompared = 0;
  int nMismatch = 0;
  bit checkEn = 1'b0;
  int sCyc = 0;

  logic        logValid[256];
  logic        logReq[256];
  logic        logGnt[256];
  logic [31:0] logPc[256];
  logic [31:0] logAddr[256];
  logic [31:0] logInst[256];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h expected %h (scenario cycle %0d)", name, act, exp, sCyc);
    end
  endtask

  function automatic logic modelReq(input logic iRst);
    return !iRst && (fifoQ.size() + liveQ.size() < DEPTH) && (liveQ.size() + stale < DEPTH);
  endfunction

  task automatic checkOutput(input logic expReq, input logic expValid);
    compare("imem_req", {31'b0, o_imem_req}, {31'b0, expReq});
    compare("imem_addr", o_imem_addr, mPc);
    compare("valid", {31'b0, o_valid}, {31'b0, expValid});
    compare("pc", o_pc, mHead);
    compare("inst", o_inst, expValid ? (fifoQ[0] ^ KEY) : NOP);
  endtask

  // One clock: drive inputs, check at negedge, then advance memory and model at posedge.
  task automatic applyStimulus(input logic iRst, input logic iGnt, input logic iReady,
                               input logic iRedir, input logic [31:0] iRpc);
    logic        expReq;
    logic        expValid;
    logic        sRvalid;
    logic        sGrantDut;
    logic [31:0] sAddr;
    int          lat;
    rst      = iRst;
    gnt      = iGnt;
    ready    = iReady;
    redirect = iRedir;
    rpc      = iRpc;
    rvalid   = (pend.size() > 0) && (pend[0].due <= cyc);
    rdata    = rvalid ? (pend[0].addr ^ KEY) : 32'hDEAD_BEEF;
    @(negedge clk);
    expReq   = modelReq(iRst);
    expValid = (fifoQ.size() != 0) && !iRedir;
    if (checkEn) checkOutput(expReq, expValid);
    if (sCyc < 256) begin
      logValid[sCyc] = o_valid;
      logReq[sCyc]   = o_imem_req;
      logGnt[sCyc]   = iGnt;
      logPc[sCyc]    = o_pc;
      logAddr[sCyc]  = o_imem_addr;
      logInst[sCyc]  = o_inst;
    end
    sRvalid   = rvalid;
    sGrantDut = o_imem_req & iGnt;
    sAddr     = o_imem_addr;
    @(posedge clk);
    lat = (latMode != 0) ? int'($urandom_range(1, 4)) : latFixed;
    if (iRst) begin
      pend.delete();
    end else begin
      if (sRvalid) void'(pend.pop_front());
      if (sGrantDut) pend.push_back('{addr: sAddr, due: cyc + lat});
    end
    if (iRst) begin
      liveQ.delete();
      fifoQ.delete();
      stale = 0;
      mPc   = RPC;
      mHead = RPC;
    end else if (iRedir) begin
      liveQ.delete();
      fifoQ.delete();
      stale = pend.size();
      mPc   = {iRpc[31:2], 2'b00};
      mHead = {iRpc[31:2], 2'b00};
    end else begin
      if (sRvalid) begin
        if (stale > 0) stale--;
        else if (liveQ.size() > 0) fifoQ.push_back(liveQ.pop_front());
      end
      if (expValid && iReady) begin
        void'(fifoQ.pop_front());
        mHead = mHead + 32'd4;
      end
      if (expReq && iGnt) begin
        liveQ.push_back(mPc);
        mPc = mPc + 32'd4;
      end
    end
    cyc++;
    sCyc++;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkEn = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    compare("rst_req", {31'b0, o_imem_req}, 32'd0);
    compare("rst_valid", {31'b0, o_valid}, 32'd0);
    compare("rst_inst", o_inst, NOP);
    compare("rst_pc", o_pc, RPC);
    compare("rst_addr", o_imem_addr, RPC);
    sCyc = 0;
  endtask

  initial begin
    int n;
    int k;
    int firstV;

    // Streaming through the address wrap with a 1-cycle memory.
    latMode = 0;
    latFixed = 1;
    doReset();
    repeat (12) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    compare("s1_c0_req", {31'b0, logReq[0]}, 32'd1);
    compare("s1_c0_addr", logAddr[0], 32'hFFFF_FFF8);
    compare("s1_c1_addr", logAddr[1], 32'hFFFF_FFFC);
    compare("s1_c2_addr", logAddr[2], 32'h0000_0000);
    compare("s1_c3_addr", logAddr[3], 32'h0000_0004);
    compare("s1_c2_pc", logPc[2], 32'hFFFF_FFF8);
    compare("s1_c2_inst", logInst[2], 32'h5A5A_FFF8);
    compare("s1_c3_pc", logPc[3], 32'hFFFF_FFFC);
    compare("s1_c4_pc", logPc[4], 32'h0000_0000);
    compare("s1_c4_inst", logInst[4], 32'hA5A5_0000);
    compare("s1_c5_pc", logPc[5], 32'h0000_0004);
    n = 0;
    for (int i = 2; i < 12; i++) n += int'(logValid[i]);
    compare("s1_steady_valid", n, 10);

    // Decode stalled: exactly DEPTH grants, then resume without loss.
    doReset();
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(logReq[i] & logGnt[i]);
    compare("s2_grants", n, DEPTH);
    compare("s2_req_idle", {31'b0, logReq[9]}, 32'd0);
    repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    compare("s2_c10_pc", logPc[10], 32'hFFFF_FFF8);
    compare("s2_c11_pc", logPc[11], 32'hFFFF_FFFC);
    compare("s2_c12_pc", logPc[12], 32'h0000_0000);
    compare("s2_c13_pc", logPc[13], 32'h0000_0004);
    compare("s2_c13_valid", {31'b0, logValid[13]}, 32'd1);

    // Redirect with two requests in flight on a 3-cycle memory.
    latFixed = 3;
    doReset();
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
    repeat (14) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    compare("s3_c3_req", {31'b0, logReq[3]}, 32'd1);
    compare("s3_c3_addr", logAddr[3], 32'h0000_0100);
    firstV = -1;
    for (int i = 3; i < 17; i++) if (logValid[i] && firstV < 0) firstV = i;
    compare("s3_first_valid_cyc", firstV, 7);
    if (firstV >= 0) begin
      compare("s3_first_pc", logPc[firstV], 32'h0000_0100);
      compare("s3_first_inst", logInst[firstV], 32'hA5A5_0100);
    end

    // Redirect coinciding with grant, response and pop.
    latFixed = 1;
    doReset();
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    compare("s4_c4_req", {31'b0, logReq[4]}, 32'd1);
    compare("s4_c4_valid", {31'b0, logValid[4]}, 32'd0);
    compare("s4_c5_addr", logAddr[5], 32'h0000_0200);
    compare("s4_c5_req", {31'b0, logReq[5]}, 32'd1);
    compare("s4_c6_valid", {31'b0, logValid[6]}, 32'd0);
    compare("s4_c7_valid", {31'b0, logValid[7]}, 32'd1);
    compare("s4_c7_pc", logPc[7], 32'h0000_0200);
    compare("s4_c7_inst", logInst[7], 32'hA5A5_0200);

    // Random latency, grants, stalls and redirects, with a reset mid-stream.
    latMode = 1;
    doReset();
    repeat (40) applyStimulus(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                              $urandom_range(0, 15) == 0, $urandom);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    k = sCyc;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    compare("s5_rst_valid", {31'b0, logValid[k]}, 32'd0);
    compare("s5_rst_pc", logPc[k], RPC);
    compare("s5_rst_addr", logAddr[k], RPC);
    compare("s5_rst_inst", logInst[k], NOP);
    compare("s5_rst_req", {31'b0, logReq[k]}, 32'd1);
    repeat (30) applyStimulus(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                              $urandom_range(0, 15) == 0, $urandom);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
